ads131_spi_frame_master: RTL and testbench

- Parametrised successor to the ADS131A0x SPI master.
- Powers up the ADC with a timed RESET pulse, then runs complete multi-word SPI frames on request.
- Each frame shifts a command word out on MOSI and captures every MISO word (status plus channels).
- Sits between the ADC pins and the sample-processing logic, clocked from the 50 MHz system_clock.

---
 rtl/ads131_spi_pkg.sv | 21 ++
 rtl/ads131_spi_frame_master_sclk.sv | 44 ++++
 rtl/ads131_spi_frame_master.sv | 141 ++++++++++++++
 tb/tb_ads131_spi_frame_master.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ads131_spi_pkg.sv
// ads131_spi_pkg: FSM states and SPI framing constants shared by the ADS131 frame master.
package ads131_spi_pkg;

    typedef enum logic [2:0] {
        ST_RST_LOW,
        ST_PWR_WAIT,
        ST_IDLE,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_CS_HOLD,
        ST_CS_GAP
    } state_t;

    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b1;

    localparam int WORD16 = 16;
    localparam int WORD24 = 24;
    localparam int WORD32 = 32;

endpackage

// File: rtl/ads131_spi_frame_master_sclk.sv
// spi_sclk_phase_gen: SCLK divider; ticks are asserted in the cycle before the edge they announce.
module spi_sclk_phase_gen
    import ads131_spi_pkg::*;
#(
    parameter int CLK_DIV = 6,
    localparam int DW = $clog2(CLK_DIV)
) (
    input  logic system_clock,
    input  logic reset_n,
    input  logic en,
    output logic sclk,
    output logic rise_tick,
    output logic fall_tick,
    output logic bit_end
);

    logic [DW-1:0] div_cnt;
    logic          ph;
    logic          wrap;

    always_comb begin
        wrap      = div_cnt == DW'(CLK_DIV - 1);
        rise_tick = en && !ph && div_cnt == '0;
        fall_tick = en && ph && div_cnt == '0;
        bit_end   = en && ph && wrap;
    end

    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            ph      <= 1'b0;
            sclk    <= CPOL;
        end else if (!en) begin
            div_cnt <= '0;
            ph      <= 1'b0;
            sclk    <= CPOL;
        end else begin
            div_cnt <= wrap ? '0 : div_cnt + 1'b1;
            ph      <= ph ^ wrap;
            sclk    <= rise_tick ? ~CPOL : fall_tick ? CPOL : sclk;
        end
    end

endmodule

// File: rtl/ads131_spi_frame_master.sv
// ads131_spi_frame_master: ADS131A0x power-up sequencer and multi-word SPI mode-1 frame engine.
module ads131_spi_frame_master
    import ads131_spi_pkg::*;
#(
    parameter int WORD_BITS      = WORD24,
    parameter int NUM_WORDS      = 5,
    parameter int CLK_DIV        = 6,
    parameter int CS_SETUP       = 2,
    parameter int CS_HOLD        = 2,
    parameter int CS_GAP         = 4,
    parameter int RESET_CYCLES   = 1000,
    parameter int POWERUP_CYCLES = 5000,
    localparam int IW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1
) (
    input  logic                 system_clock,
    input  logic                 reset_n,
    input  logic                 frame_start,
    input  logic [WORD_BITS-1:0] cmd_word,
    output logic                 SPI_SCLK,
    output logic                 SPI_MOSI,
    input  logic                 SPI_MISO,
    output logic                 SPI_CS,
    output logic                 SPI_RESET,
    output logic [WORD_BITS-1:0] rx_word,
    output logic [IW-1:0]        rx_idx,
    output logic                 rx_valid,
    output logic                 frame_done,
    output logic                 busy,
    output logic                 init_done
);

    localparam int BW = $clog2(WORD_BITS);

    state_t               state;
    logic [31:0]          cnt;
    logic [BW-1:0]        bit_cnt;
    logic [IW-1:0]        word_cnt;
    logic [WORD_BITS-1:0] tx_sr;
    logic [WORD_BITS-2:0] rx_sr;
    logic                 sclk_en, rise_tick, fall_tick, bit_end, launch, capture, last_bit;

    // The divider runs one cycle early so the first SCLK rise lands exactly CS_SETUP clocks after CS falls.
    always_comb begin
        sclk_en  = state == ST_SHIFT || (state == ST_CS_SETUP && cnt == 32'(CS_SETUP - 1));
        launch   = CPHA ? rise_tick : fall_tick;
        capture  = CPHA ? fall_tick : rise_tick;
        last_bit = bit_cnt == BW'(WORD_BITS - 1);
    end

    spi_sclk_phase_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .system_clock(system_clock),
        .reset_n     (reset_n),
        .en          (sclk_en),
        .sclk        (SPI_SCLK),
        .rise_tick   (rise_tick),
        .fall_tick   (fall_tick),
        .bit_end     (bit_end)
    );

    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_RST_LOW;
            cnt        <= '0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            SPI_CS     <= 1'b1;
            SPI_MOSI   <= 1'b0;
            SPI_RESET  <= 1'b0;
            rx_word    <= '0;
            rx_idx     <= '0;
            rx_valid   <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b1;
            init_done  <= 1'b0;
        end else begin
            rx_valid   <= 1'b0;
            frame_done <= 1'b0;
            cnt        <= cnt + 32'd1;
            if (launch) begin
                SPI_MOSI <= tx_sr[WORD_BITS-1];
                tx_sr    <= tx_sr << 1;
            end
            if (capture) begin
                rx_sr <= {rx_sr[WORD_BITS-3:0], SPI_MISO};
                if (last_bit) begin
                    rx_word  <= {rx_sr, SPI_MISO};
                    rx_idx   <= word_cnt;
                    rx_valid <= 1'b1;
                end
            end
            case (state)
                ST_RST_LOW: if (cnt == 32'(RESET_CYCLES - 1)) begin
                    state     <= ST_PWR_WAIT;
                    SPI_RESET <= 1'b1;
                    cnt       <= '0;
                end
                ST_PWR_WAIT: if (cnt == 32'(POWERUP_CYCLES - 1)) begin
                    state     <= ST_IDLE;
                    init_done <= 1'b1;
                    busy      <= 1'b0;
                end
                ST_IDLE: if (frame_start) begin
                    state    <= ST_CS_SETUP;
                    SPI_CS   <= 1'b0;
                    busy     <= 1'b1;
                    tx_sr    <= cmd_word;
                    bit_cnt  <= '0;
                    word_cnt <= '0;
                    cnt      <= '0;
                end
                ST_CS_SETUP: if (cnt == 32'(CS_SETUP - 1)) state <= ST_SHIFT;
                ST_SHIFT: if (bit_end) begin
                    bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
                    if (last_bit && word_cnt == IW'(NUM_WORDS - 1)) begin
                        state    <= ST_CS_HOLD;
                        SPI_MOSI <= 1'b0;
                        cnt      <= '0;
                    end else if (last_bit) begin
                        word_cnt <= word_cnt + 1'b1;
                    end
                end
                // One extra count here covers the final SCLK-low cycle that follows bit_end.
                ST_CS_HOLD: if (cnt == 32'(CS_HOLD)) begin
                    state      <= ST_CS_GAP;
                    SPI_CS     <= 1'b1;
                    frame_done <= 1'b1;
                    cnt        <= 32'd1;
                end
                // The IDLE sampling cycle is counted as the last gap clock.
                ST_CS_GAP: if (cnt >= 32'(CS_GAP - 1)) begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_RST_LOW;
            endcase
        end
    end

endmodule

// File: tb/tb_ads131_spi_frame_master.sv
// tb_ads131_spi_frame_master: directed checks of power-up, framing, gaps and mid-frame reset.
module tb_ads131_spi_frame_master;

    logic system_clock = 1'b0;
    always #5 system_clock = ~system_clock;

    int tests = 0;
    int fails = 0;

    logic       a_rst_n, a_start, a_sclk, a_mosi, a_cs, a_spi_reset, a_rxv, a_fd, a_busy, a_init;
    logic       a_miso = 1'b0;
    logic [7:0] a_cmd, a_rxw;
    logic [0:0] a_rxi;

    logic        b_rst_n, b_start, b_sclk, b_mosi, b_cs, b_spi_reset, b_rxv, b_fd, b_busy, b_init;
    logic        b_miso = 1'b0;
    logic [23:0] b_cmd, b_rxw;
    logic [2:0]  b_rxi;

    ads131_spi_frame_master #(
        .WORD_BITS(8), .NUM_WORDS(2), .CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2),
        .CS_GAP(4), .RESET_CYCLES(4), .POWERUP_CYCLES(8)
    ) u_a (
        .system_clock(system_clock), .reset_n(a_rst_n), .frame_start(a_start), .cmd_word(a_cmd),
        .SPI_SCLK(a_sclk), .SPI_MOSI(a_mosi), .SPI_MISO(a_miso), .SPI_CS(a_cs), .SPI_RESET(a_spi_reset),
        .rx_word(a_rxw), .rx_idx(a_rxi), .rx_valid(a_rxv), .frame_done(a_fd), .busy(a_busy), .init_done(a_init)
    );

    ads131_spi_frame_master #(
        .WORD_BITS(24), .NUM_WORDS(5), .CLK_DIV(6), .CS_SETUP(2), .CS_HOLD(2),
        .CS_GAP(4), .RESET_CYCLES(4), .POWERUP_CYCLES(8)
    ) u_b (
        .system_clock(system_clock), .reset_n(b_rst_n), .frame_start(b_start), .cmd_word(b_cmd),
        .SPI_SCLK(b_sclk), .SPI_MOSI(b_mosi), .SPI_MISO(b_miso), .SPI_CS(b_cs), .SPI_RESET(b_spi_reset),
        .rx_word(b_rxw), .rx_idx(b_rxi), .rx_valid(b_rxv), .frame_done(b_fd), .busy(b_busy), .init_done(b_init)
    );

    // ADC models: shift the next response bit out on each SCLK rise, restart at CS fall.
    logic [7:0]  a_words [2] = '{8'h3C, 8'hC3};
    logic [23:0] b_words [5] = '{24'h3C5A01, 24'hC3A502, 24'h123456, 24'hABCDEF, 24'h800001};
    int a_pos = 0;
    int b_pos = 0;
    always @(negedge a_cs) a_pos = 0;
    always @(negedge b_cs) b_pos = 0;
    always @(posedge a_sclk) begin
        a_miso = a_words[(a_pos / 8) % 2][7 - a_pos % 8];
        a_pos  = a_pos + 1;
    end
    always @(posedge b_sclk) begin
        b_miso = b_words[(b_pos / 24) % 5][23 - b_pos % 24];
        b_pos  = b_pos + 1;
    end

    // Pin monitors sampled mid-cycle.
    bit         a_sclk_q, b_sclk_q;
    int         a_low, a_high, a_fd_cnt, b_low, b_fd_cnt;
    int         a_low_q[$], a_high_q[$], a_rxi_q[$], b_low_q[$], b_rxi_q[$];
    bit         a_mosi_q[$], b_mosi_q[$];
    logic [7:0] a_rxw_q[$];
    logic [23:0] b_rxw_q[$];

    always @(negedge system_clock) begin
        if (a_sclk && !a_sclk_q) a_mosi_q.push_back(a_mosi);
        a_sclk_q = a_sclk;
        if (a_rxv) begin
            a_rxw_q.push_back(a_rxw);
            a_rxi_q.push_back(int'(a_rxi));
        end
        if (a_fd) a_fd_cnt++;
        if (!a_cs) begin
            a_low++;
            if (a_high != 0) a_high_q.push_back(a_high);
            a_high = 0;
        end else begin
            a_high++;
            if (a_low != 0) a_low_q.push_back(a_low);
            a_low = 0;
        end
        if (b_sclk && !b_sclk_q) b_mosi_q.push_back(b_mosi);
        b_sclk_q = b_sclk;
        if (b_rxv) begin
            b_rxw_q.push_back(b_rxw);
            b_rxi_q.push_back(int'(b_rxi));
        end
        if (b_fd) b_fd_cnt++;
        if (!b_cs) b_low++;
        else begin
            if (b_low != 0) b_low_q.push_back(b_low);
            b_low = 0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge system_clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_a();
        a_low_q.delete();
        a_high_q.delete();
        a_mosi_q.delete();
        a_rxw_q.delete();
        a_rxi_q.delete();
        a_fd_cnt = 0;
    endtask

    initial begin
        logic [15:0] w16;
        logic [23:0] w24;
        bit          ok, any;
        int          rise_at, init_at;
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        a_start = 1'b0; b_start = 1'b0;
        a_cmd = '0; b_cmd = '0;
        #1;
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        cyc(2);
        chk("rst_cs", a_cs, 1);
        chk("rst_sclk", a_sclk, 0);
        chk("rst_mosi", a_mosi, 0);
        chk("rst_spi_reset", a_spi_reset, 0);
        chk("rst_rx_word", a_rxw, 0);
        chk("rst_rx_idx", a_rxi, 0);
        chk("rst_rx_valid", a_rxv, 0);
        chk("rst_frame_done", a_fd, 0);
        chk("rst_busy", a_busy, 1);
        chk("rst_init_done", a_init, 0);

        // Power-up, with a frame_start pulse landing in PWR_WAIT.
        a_rst_n = 1'b1;
        rise_at = 0; init_at = 0; ok = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            a_start = (i == 6);
            cyc(1);
            if (a_spi_reset && rise_at == 0) rise_at = i;
            if (a_init && init_at == 0) init_at = i;
            if (a_cs !== 1'b1 || a_sclk !== 1'b0) ok = 1'b0;
        end
        a_start = 1'b0;
        chk("pwr_reset_rise_cycle", rise_at, 4);
        chk("pwr_init_rise_cycle", init_at, 12);
        chk("pwr_pins_idle", ok, 1);
        chk("pwr_start_ignored", a_low_q.size() + a_low, 0);
        chk("idle_busy", a_busy, 0);

        // Single frame; a second start and a cmd change arrive mid-SHIFT.
        clear_a();
        a_cmd = 8'hA5; a_start = 1'b1;
        cyc(1);
        a_start = 1'b0;
        cyc(20);
        a_cmd = 8'hFF; a_start = 1'b1;
        cyc(1);
        a_start = 1'b0;
        for (int i = 0; i < 200 && a_fd_cnt == 0; i++) cyc(1);
        cyc(12);
        chk("f1_mosi_count", a_mosi_q.size(), 16);
        w16 = '0;
        for (int i = 0; i < a_mosi_q.size(); i++) w16 = {w16[14:0], a_mosi_q[i]};
        chk("f1_mosi_bits", w16, 16'hA500);
        chk("f1_rx_count", a_rxw_q.size(), 2);
        chk("f1_rx0_word", a_rxw_q[0], 8'h3C);
        chk("f1_rx0_idx", a_rxi_q[0], 0);
        chk("f1_rx1_word", a_rxw_q[1], 8'hC3);
        chk("f1_rx1_idx", a_rxi_q[1], 1);
        chk("f1_cs_low_len", a_low_q[0], 68);
        chk("f1_frame_done_count", a_fd_cnt, 1);
        chk("f1_no_extra_frame", a_low_q.size() + a_low, 1);
        chk("f1_busy_after", a_busy, 0);

        // frame_start held high: back-to-back frames.
        clear_a();
        a_start = 1'b1;
        for (int i = 0; i < 600 && a_low_q.size() < 3; i++) cyc(1);
        a_start = 1'b0;
        cyc(12);
        chk("b2b_frame_count", a_low_q.size() + a_low, 3);
        chk("b2b_gap_1", a_high_q[1], 4);
        chk("b2b_gap_2", a_high_q[2], 4);
        chk("b2b_cs_low_len", a_low_q[2], 68);
        chk("b2b_rx_count", a_rxw_q.size(), 6);
        chk("b2b_rx4_word", a_rxw_q[4], 8'h3C);
        chk("b2b_rx5_idx", a_rxi_q[5], 1);
        chk("b2b_frame_done_count", a_fd_cnt, 3);

        // Reset asserted during bit 5 of word 1.
        clear_a();
        a_cmd = 8'hA5; a_start = 1'b1;
        cyc(1);
        a_start = 1'b0;
        cyc(54);
        chk("mid_sclk_high", a_sclk, 1);
        chk("mid_bit_position", a_mosi_q.size(), 14);
        a_rst_n = 1'b0;
        #1;
        chk("mid_rst_cs", a_cs, 1);
        chk("mid_rst_sclk", a_sclk, 0);
        chk("mid_rst_spi_reset", a_spi_reset, 0);
        chk("mid_rst_busy", a_busy, 1);
        chk("mid_rst_init_done", a_init, 0);
        cyc(3);
        chk("mid_rst_rx_count", a_rxw_q.size(), 1);
        chk("mid_rst_rx_word", a_rxw, 0);
        chk("mid_rst_frame_done", a_fd_cnt, 0);
        a_rst_n = 1'b1;
        cyc(3);
        chk("restart_reset_low", a_spi_reset, 0);
        cyc(1);
        chk("restart_reset_high", a_spi_reset, 1);
        cyc(7);
        chk("restart_init_pending", a_init, 0);
        cyc(1);
        chk("restart_init_done", a_init, 1);

        // Wide configuration: 24-bit words, 5 words, CLK_DIV 6.
        b_rst_n = 1'b1;
        for (int i = 0; i < 40 && !b_init; i++) cyc(1);
        chk("w_init_done", b_init, 1);
        b_cmd = 24'hA50F3C; b_start = 1'b1;
        cyc(1);
        b_start = 1'b0;
        for (int i = 0; i < 3000 && b_fd_cnt == 0; i++) cyc(1);
        cyc(2);
        chk("w_frame_done_count", b_fd_cnt, 1);
        chk("w_cs_low_len", b_low_q[0], 1444);
        chk("w_rx_count", b_rxw_q.size(), 5);
        for (int k = 0; k < 5; k++) begin
            chk("w_rx_idx", b_rxi_q[k], k);
            chk("w_rx_word", b_rxw_q[k], b_words[k]);
        end
        chk("w_mosi_count", b_mosi_q.size(), 120);
        w24 = '0; any = 1'b0;
        for (int i = 0; i < b_mosi_q.size(); i++) begin
            if (i < 24) w24 = {w24[22:0], b_mosi_q[i]};
            else any = any | b_mosi_q[i];
        end
        chk("w_mosi_cmd", w24, 24'hA50F3C);
        chk("w_mosi_zero_fill", any, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
